// File: rtl/servo_sched_pkg.sv
// Shared types, default parameter values and the duty slew rule for the servo command scheduler.
package servo_sched_pkg;

    localparam int unsigned DefNReq          = 4;
    localparam int unsigned DefNChannels     = 4;
    localparam int unsigned DefNBits         = 2;
    localparam int unsigned DefHoldoffCycles = 16;
    localparam int unsigned DefMaxStep       = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } sched_state_e;

    // Move cur toward tgt by at most max_step (0 = jump straight to tgt); never wraps.
    function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt,
                                             input int unsigned max_step);
        logic [7:0]  d8;
        int unsigned diff;
        d8   = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        diff = 32'(d8);
        if (max_step == 0 || diff <= max_step) begin
            return tgt;
        end
        if (tgt > cur) begin
            return cur + max_step[7:0];
        end
        return cur - max_step[7:0];
    endfunction

endpackage

// File: rtl/servo_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after rr_ptr, wrapping.
module servo_rr_arbiter
    import servo_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    int unsigned idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % N_REQ;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/servo_cmd_scheduler.sv
// Arbitrates duty-cycle write requests and drives a latch-strobed servo PWM controller,
// slew-limiting each channel against a shadow copy of the last written duty.
module servo_cmd_scheduler
    import servo_sched_pkg::*;
#(
    parameter int unsigned N_REQ          = DefNReq,
    parameter int unsigned N_CHANNELS     = DefNChannels,
    parameter int unsigned NBITS          = DefNBits,
    parameter int unsigned HOLDOFF_CYCLES = DefHoldoffCycles,
    parameter int unsigned MAX_STEP       = DefMaxStep
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*NBITS-1:0]   req_addr,
    input  logic [N_REQ*8-1:0]       req_duty,
    output logic [N_REQ-1:0]         ack,
    output logic                     err,
    output logic                     busy,
    output logic [NBITS-1:0]         address,
    output logic [7:0]               dutycycle,
    output logic                     latch
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CntW-1:0] HoldLast =
        CntW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    sched_state_e     state_q, state_d;
    logic [NBITS-1:0] addr_q, addr_d;
    logic [7:0]       target_q, target_d;
    logic [NBITS-1:0] address_q, address_d;
    logic [7:0]       duty_q, duty_d;
    logic             latch_q, latch_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]       shadow_q [N_CHANNELS];

    logic [N_REQ-1:0] grant;
    logic             grant_valid;
    int unsigned      gnt_idx;
    logic [NBITS-1:0] sel_addr;
    logic [7:0]       sel_duty;
    logic [7:0]       sel_cur;
    logic [7:0]       sel_next;
    logic             sel_in_range;
    logic [7:0]       hold_next;
    logic             finish;

    servo_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PtrW)
    ) u_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (grant),
        .valid  (grant_valid)
    );

    // Select the granted requester's payload and its channel's shadow duty.
    always_comb begin
        gnt_idx = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = i;
            end
        end
        sel_addr     = req_addr[gnt_idx*NBITS +: NBITS];
        sel_duty     = req_duty[gnt_idx*8 +: 8];
        sel_in_range = 32'(sel_addr) < N_CHANNELS;
        sel_cur      = '0;
        for (int unsigned c = 0; c < N_CHANNELS; c++) begin
            if (32'(sel_addr) == c) begin
                sel_cur = shadow_q[c];
            end
        end
        sel_next  = slew_step(sel_cur, sel_duty, MAX_STEP);
        // After a strobe, duty_q equals shadow[addr_q], so it is the base for the next step.
        hold_next = slew_step(duty_q, target_q, MAX_STEP);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        target_d   = target_q;
        address_d  = address_q;
        duty_d     = duty_q;
        latch_d    = 1'b1;
        ack_d      = '0;
        err_d      = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        finish     = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    ack_d    = grant;
                    rr_ptr_d = PtrW'((gnt_idx + 1) % N_REQ);
                    if (sel_in_range) begin
                        addr_d    = sel_addr;
                        target_d  = sel_duty;
                        address_d = sel_addr;
                        duty_d    = sel_next;
                        state_d   = StSetup;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                latch_d = 1'b0;
                state_d = StStrobe;
            end
            StStrobe: begin
                hold_cnt_d = '0;
                if (HOLDOFF_CYCLES == 0) begin
                    finish = 1'b1;
                end else begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
                    finish = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Keep stepping the same channel until the shadow reaches the captured target.
        if (finish) begin
            if (duty_q != target_q) begin
                duty_d  = hold_next;
                state_d = StSetup;
            end else begin
                state_d = StIdle;
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            target_q   <= '0;
            address_q  <= '0;
            duty_q     <= '0;
            latch_q    <= 1'b1;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            for (int unsigned c = 0; c < N_CHANNELS; c++) begin
                shadow_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            target_q   <= target_d;
            address_q  <= address_d;
            duty_q     <= duty_d;
            latch_q    <= latch_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            if (state_q == StStrobe) begin
                for (int unsigned c = 0; c < N_CHANNELS; c++) begin
                    if (32'(addr_q) == c) begin
                        shadow_q[c] <= duty_q;
                    end
                end
            end
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign address   = address_q;
    assign dutycycle = duty_q;
    assign latch     = latch_q;

endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// Self-checking bench for servo_cmd_scheduler: directed vector table, corner sequences,
// and randomized batches checked against a transaction-level model.
module tb_servo_cmd_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned NCH   = 3;
    localparam int unsigned NB    = 2;
    localparam int unsigned HOLD  = 16;
    localparam int unsigned MSTEP = 8;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*NB-1:0]   req_addr;
    logic [NREQ*8-1:0]    req_duty;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic                 busy;
    logic [NB-1:0]        address;
    logic [7:0]           dutycycle;
    logic                 latch;

    servo_cmd_scheduler #(
        .N_REQ          (NREQ),
        .N_CHANNELS     (NCH),
        .NBITS          (NB),
        .HOLDOFF_CYCLES (HOLD),
        .MAX_STEP       (MSTEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_duty  (req_duty),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .address   (address),
        .dutycycle (dutycycle),
        .latch     (latch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int addr;
        int duty;
        int exp_err;
        int exp_nwr;
        int exp_first;
        int exp_last;
    } vec_t;

    typedef struct {
        int addr;
        int duty;
        int cyc;
    } wr_t;

    vec_t vecs[11];
    int   obs_ack[$];
    int   obs_ack_cyc[$];
    int   obs_err[$];
    wr_t  obs_wr[$];
    int   exp_ack[$];
    int   exp_err[$];
    wr_t  exp_wr[$];
    int   stray_err;
    int   busy_seen;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    bit   auto_drop;
    int   sh[NCH];
    int   rr;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample outputs 1ns after the edge and record observed events.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (ack[i]) begin
                obs_ack.push_back(i);
                obs_ack_cyc.push_back(cyc);
                obs_err.push_back(int'(err));
                if (auto_drop) req[i] = 1'b0;
            end
        end
        if (err && ack == '0) stray_err++;
        if (!latch) obs_wr.push_back('{int'(address), int'(dutycycle), cyc});
        if (busy) busy_seen = 1;
    endtask

    task automatic clear_obs();
        obs_ack.delete();
        obs_ack_cyc.delete();
        obs_err.delete();
        obs_wr.delete();
        stray_err = 0;
        busy_seen = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic set_req(input int idx, input int addr, input int duty);
        req_addr[idx*NB +: NB] = addr[NB-1:0];
        req_duty[idx*8 +: 8]   = duty[7:0];
        req[idx]               = 1'b1;
    endtask

    task automatic run_one(input int idx, input int addr, input int duty, output int fall_cyc);
        int n;
        clear_obs();
        set_req(idx, addr, duty);
        n = 0;
        while (obs_ack.size() == 0 && n < 20) begin
            step();
            n++;
        end
        if (obs_ack.size() == 0) begin
            chk("ack_timeout", 0, 1);
            req[idx] = 1'b0;
        end
        n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        if (busy) chk("busy_stuck", 1, 0);
        fall_cyc = cyc;
        repeat (3) step();
    endtask

    // Transaction-level model: grant order by rotation, then the whole slew sequence per grant.
    task automatic model_batch(input logic [NREQ-1:0] mask_in, input int a_t[NREQ],
                               input int d_t[NREQ]);
        logic [NREQ-1:0] mask;
        int g, cur, t, a;
        mask = mask_in;
        while (mask != '0) begin
            g = -1;
            for (int k = 0; k < int'(NREQ); k++) begin
                if (g < 0 && mask[(rr + k) % NREQ]) g = (rr + k) % NREQ;
            end
            mask[g] = 1'b0;
            rr = (g + 1) % NREQ;
            exp_ack.push_back(g);
            a = a_t[g];
            t = d_t[g];
            if (a >= int'(NCH)) begin
                exp_err.push_back(1);
            end else begin
                exp_err.push_back(0);
                cur = sh[a];
                do begin
                    if ((t > cur ? t - cur : cur - t) <= int'(MSTEP)) cur = t;
                    else cur = (t > cur) ? cur + MSTEP : cur - MSTEP;
                    exp_wr.push_back('{a, cur, 0});
                end while (cur != t);
                sh[a] = t;
            end
        end
    endtask

    initial begin
        int fall;
        int bad;
        int n;
        int rr_exp[5];
        int a_t[NREQ];
        int d_t[NREQ];
        logic [NREQ-1:0] mask;

        clk = 1'b0; reset = 1'b1; req = '0; req_addr = '0; req_duty = '0;
        auto_drop = 1'b1; cyc = 0; n_cmp = 0; n_fail = 0;
        clear_obs();

        vecs[0]  = '{0, 2, 8'h05, 0, 1,  8'h05, 8'h05};
        vecs[1]  = '{1, 1, 8'h20, 0, 4,  8'h08, 8'h20};
        vecs[2]  = '{1, 1, 8'h1C, 0, 1,  8'h1C, 8'h1C};
        vecs[3]  = '{2, 3, 8'h44, 1, 0,  0,     0};
        vecs[4]  = '{3, 0, 8'h13, 0, 3,  8'h08, 8'h13};
        vecs[5]  = '{0, 2, 8'h00, 0, 1,  8'h00, 8'h00};
        vecs[6]  = '{2, 0, 8'h13, 0, 1,  8'h13, 8'h13};
        vecs[7]  = '{3, 1, 8'h14, 0, 1,  8'h14, 8'h14};
        vecs[8]  = '{0, 1, 8'h0B, 0, 2,  8'h0C, 8'h0B};
        vecs[9]  = '{1, 0, 8'hFF, 0, 30, 8'h1B, 8'hFF};
        vecs[10] = '{2, 0, 8'hF7, 0, 1,  8'hF7, 8'hF7};

        // Reset values.
        repeat (3) step();
        chk("rst latch", int'(latch), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst ack", int'(ack), 0);
        chk("rst err", int'(err), 0);
        chk("rst address", int'(address), 0);
        chk("rst dutycycle", int'(dutycycle), 0);
        reset = 1'b0;
        clear_obs();

        // Directed vector table, applied back to back from reset.
        for (int i = 0; i < 11; i++) begin
            run_one(vecs[i].idx, vecs[i].addr, vecs[i].duty, fall);
            chk($sformatf("v%0d ack_count", i), obs_ack.size(), 1);
            if (obs_ack.size() > 0) begin
                chk($sformatf("v%0d ack_idx", i), obs_ack[0], vecs[i].idx);
                chk($sformatf("v%0d err", i), obs_err[0], vecs[i].exp_err);
            end
            chk($sformatf("v%0d stray_err", i), stray_err, 0);
            chk($sformatf("v%0d n_writes", i), obs_wr.size(), vecs[i].exp_nwr);
            if (vecs[i].exp_err != 0) chk($sformatf("v%0d busy_seen", i), busy_seen, 0);
            if (vecs[i].exp_nwr > 0 && obs_wr.size() > 0 && obs_ack.size() > 0) begin
                chk($sformatf("v%0d first_duty", i), obs_wr[0].duty, vecs[i].exp_first);
                chk($sformatf("v%0d last_duty", i), obs_wr[obs_wr.size()-1].duty,
                    vecs[i].exp_last);
                chk($sformatf("v%0d latch_latency", i), obs_wr[0].cyc - obs_ack_cyc[0], 1);
                bad = 0;
                foreach (obs_wr[j]) begin
                    if (obs_wr[j].addr != vecs[i].addr) bad++;
                    if (j > 0 && obs_wr[j].cyc - obs_wr[j-1].cyc != int'(HOLD) + 2) bad++;
                end
                chk($sformatf("v%0d addr_spacing_bad", i), bad, 0);
                chk($sformatf("v%0d busy_fall", i), fall - obs_wr[obs_wr.size()-1].cyc,
                    int'(HOLD) + 1);
            end
        end

        // Round robin with 0, 2, 3 held continuously.
        do_reset(2);
        rr_exp = '{0, 2, 3, 0, 2};
        auto_drop = 1'b0;
        set_req(0, 0, 0);
        set_req(2, 1, 0);
        set_req(3, 2, 0);
        n = 0;
        while (obs_ack.size() < 5 && n < 500) begin
            step();
            n++;
        end
        req = '0;
        auto_drop = 1'b1;
        chk("rr ack_count", obs_ack.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < obs_ack.size()) chk($sformatf("rr grant%0d", i), obs_ack[i], rr_exp[i]);
        end
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end

        // Reset inside HOLD abandons a slewing transfer.
        do_reset(2);
        set_req(1, 1, 8'h40);
        n = 0;
        while (obs_wr.size() == 0 && n < 20) begin
            step();
            n++;
        end
        chk("midrst first_write", obs_wr.size(), 1);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst address", int'(address), 0);
        chk("midrst dutycycle", int'(dutycycle), 0);
        chk("midrst req_dropped", int'(req), 0);
        clear_obs();
        repeat (40) step();
        chk("midrst latch_pulses", obs_wr.size(), 0);
        chk("midrst acks", obs_ack.size(), 0);
        chk("midrst busy_seen", busy_seen, 0);
        run_one(1, 1, 8'h10, fall);
        chk("midrst restart_nwr", obs_wr.size(), 2);
        if (obs_wr.size() > 0) chk("midrst restart_first", obs_wr[0].duty, 8'h08);

        // Randomized batches against the model.
        do_reset(2);
        for (int c = 0; c < int'(NCH); c++) sh[c] = 0;
        rr = 0;
        for (int b = 0; b < 30; b++) begin
            int base;
            int d;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int j = 0; j < int'(NREQ); j++) begin
                a_t[j] = $urandom_range(0, 3);
                base = (a_t[j] < int'(NCH)) ? sh[a_t[j]] : 0;
                if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 255);
                else d = base + int'($urandom_range(0, 48)) - 24;
                if (d < 0) d = 0;
                if (d > 255) d = 255;
                d_t[j] = d;
                req_addr[j*NB +: NB] = a_t[j][NB-1:0];
                req_duty[j*8 +: 8]   = d_t[j][7:0];
            end
            exp_ack.delete();
            exp_err.delete();
            exp_wr.delete();
            model_batch(mask, a_t, d_t);
            clear_obs();
            req = mask;
            n = 0;
            while ((req != '0 || busy) && n < 4000) begin
                step();
                n++;
            end
            chk($sformatf("rand%0d done", b), int'(req != '0 || busy), 0);
            repeat (3) step();
            chk($sformatf("rand%0d n_acks", b), obs_ack.size(), exp_ack.size());
            chk($sformatf("rand%0d n_writes", b), obs_wr.size(), exp_wr.size());
            bad = 0;
            foreach (exp_ack[j]) begin
                if (j < obs_ack.size()) begin
                    if (obs_ack[j] != exp_ack[j] || obs_err[j] != exp_err[j]) bad++;
                end
            end
            foreach (exp_wr[j]) begin
                if (j < obs_wr.size()) begin
                    if (obs_wr[j].addr != exp_wr[j].addr || obs_wr[j].duty != exp_wr[j].duty)
                        bad++;
                    if (j > 0 && obs_wr[j].cyc - obs_wr[j-1].cyc < int'(HOLD) + 2) bad++;
                end
            end
            chk($sformatf("rand%0d content_bad", b), bad, 0);
            chk($sformatf("rand%0d stray_err", b), stray_err, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
